// File: rtl/io_frontend_ctrl_pkg.sv
// Shared types and default sizes for the pad-side IO front end.
// Holds the sequencer state encoding and the default channel/config/sync sizes
// that the top-level wrapper generator also uses.
package io_frontend_pkg;

    localparam int unsigned IO_N_IO_DEFAULT        = 48;
    localparam int unsigned IO_NBIT_PADCFG_DEFAULT = 6;
    localparam int unsigned IO_SYNC_STAGES_DEFAULT = 2;

    // Post-reset sequencer: settle window, one-cycle strap latch, then run.
    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LATCH  = 2'd1,
        RUN    = 2'd2
    } io_state_e;

endpackage

// File: rtl/io_frontend_ctrl_if.sv
// Bundle of the pad-side and core-side buses of io_frontend_ctrl.
// Modports:
//   master - the surroundings: drives raw pad/strap inputs, core outputs/enables,
//            pad config and filter controls; observes everything the front end drives.
//   slave  - the front end itself.
// Signals:
//   pad_in_i, strap_i        raw asynchronous pad and strap values
//   core_out_i, core_oe_i    output data/enables from the core
//   pad_cfg_i                per-pad configuration words from the core
//   filt_en_i, filt_len_i    per-channel filter enable, global filter length
//   core_in_o                filtered inputs to the core
//   pad_out_o, pad_oe_o      output data/enables to the pads
//   pad_cfg_o                configuration to the pads
//   strap_o, strap_valid_o   latched straps and "IO released" flag
interface io_frontend_ctrl_if import io_frontend_pkg::*; #(
    parameter int unsigned N_IO        = IO_N_IO_DEFAULT,
    parameter int unsigned NBIT_PADCFG = IO_NBIT_PADCFG_DEFAULT,
    parameter int unsigned FILT_W      = 4,
    parameter int unsigned N_STRAP     = 2
) ();

    logic [N_IO-1:0]             pad_in_i;
    logic [N_STRAP-1:0]          strap_i;
    logic [N_IO-1:0]             core_out_i;
    logic [N_IO-1:0]             core_oe_i;
    logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_i;
    logic [N_IO-1:0]             filt_en_i;
    logic [FILT_W-1:0]           filt_len_i;

    logic [N_IO-1:0]             core_in_o;
    logic [N_IO-1:0]             pad_out_o;
    logic [N_IO-1:0]             pad_oe_o;
    logic [N_IO*NBIT_PADCFG-1:0] pad_cfg_o;
    logic [N_STRAP-1:0]          strap_o;
    logic                        strap_valid_o;

    modport master (
        output pad_in_i, strap_i, core_out_i, core_oe_i, pad_cfg_i, filt_en_i, filt_len_i,
        input  core_in_o, pad_out_o, pad_oe_o, pad_cfg_o, strap_o, strap_valid_o
    );

    modport slave (
        input  pad_in_i, strap_i, core_out_i, core_oe_i, pad_cfg_i, filt_en_i, filt_len_i,
        output core_in_o, pad_out_o, pad_oe_o, pad_cfg_o, strap_o, strap_valid_o
    );

endinterface

// File: rtl/io_frontend_ctrl_glitch_filter.sv
// Single input channel: SYNC_STAGES-flop synchroniser followed by a glitch filter.
// A change on the synchronised value must persist max(filt_len_i,1) consecutive cycles
// before it reaches filt_o; any agreeing cycle restarts the count. With the filter
// disabled the filtered register simply tracks the synchroniser output.
// Ports:
//   clk_i, rstn_i  core clock, async active-low reset
//   pad_i          raw asynchronous pad value
//   filt_en_i      filter enable for this channel
//   filt_len_i     required persistence length L (0 behaves as 1)
//   filt_o         filtered, registered value
module io_glitch_filter import io_frontend_pkg::*; #(
    parameter int unsigned SYNC_STAGES = IO_SYNC_STAGES_DEFAULT,
    parameter int unsigned FILT_W      = 4,
    parameter logic        RST_VAL_BIT = 1'b0
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              pad_i,
    input  logic              filt_en_i,
    input  logic [FILT_W-1:0] filt_len_i,
    output logic              filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    logic                   filt_q, filt_d;
    logic [FILT_W-1:0]      cnt_q, cnt_d;
    logic [FILT_W-1:0]      len_eff;
    logic [FILT_W:0]        cnt_inc;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL_BIT}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        len_eff = (filt_len_i == '0) ? FILT_W'(1) : filt_len_i;
        // One extra bit so the compare stays correct even if L shrank mid-count.
        cnt_inc = {1'b0, cnt_q} + (FILT_W+1)'(1);
        filt_d  = filt_q;
        cnt_d   = '0;
        if (!filt_en_i) begin
            filt_d = sync_s;
        end else if (sync_s != filt_q) begin
            if (cnt_inc >= {1'b0, len_eff}) begin
                filt_d = sync_s;
            end else begin
                cnt_d = cnt_inc[FILT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            filt_q <= RST_VAL_BIT;
            cnt_q  <= '0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/io_frontend_ctrl.sv
// Pad-side front end between the pad instances and the core.
// - Every pad input is synchronised and glitch-filtered per channel.
// - Pad output data and configuration pass straight through.
// - Output enables are held low until the post-reset sequencer reaches RUN.
// - Boot straps are synchronised, latched once at the end of the settle window and
//   then frozen until the next reset.
// Ports:
//   clk_i   core reference clock
//   rstn_i  asynchronous active-low reset
//   bus     io_frontend_ctrl_if slave modport carrying all pad/core/strap signals
module io_frontend_ctrl import io_frontend_pkg::*; #(
    parameter int unsigned     N_IO        = IO_N_IO_DEFAULT,
    parameter int unsigned     NBIT_PADCFG = IO_NBIT_PADCFG_DEFAULT,
    parameter int unsigned     SYNC_STAGES = IO_SYNC_STAGES_DEFAULT,
    parameter int unsigned     FILT_W      = 4,
    parameter int unsigned     N_STRAP     = 2,
    parameter int unsigned     SETTLE_CYC  = 16,
    parameter logic [N_IO-1:0] RST_VAL     = '0
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    io_frontend_ctrl_if.slave  bus
);

    localparam int unsigned      CntW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(SETTLE_CYC - 1);

    // ------------------------------------------------------------------
    // Input channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_IO; i++) begin : g_chan
        io_glitch_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W),
            .RST_VAL_BIT (RST_VAL[i])
        ) u_filt (
            .clk_i      (clk_i),
            .rstn_i     (rstn_i),
            .pad_i      (bus.pad_in_i[i]),
            .filt_en_i  (bus.filt_en_i[i]),
            .filt_len_i (bus.filt_len_i),
            .filt_o     (bus.core_in_o[i])
        );
    end

    // ------------------------------------------------------------------
    // Strap synchronisers (unfiltered)
    // ------------------------------------------------------------------
    logic [N_STRAP-1:0] strap_sync_q [SYNC_STAGES];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                strap_sync_q[k] <= '0;
            end
        end else begin
            strap_sync_q[0] <= bus.strap_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                strap_sync_q[k] <= strap_sync_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Post-reset sequencer and strap latch
    // ------------------------------------------------------------------
    io_state_e          state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [N_STRAP-1:0] strap_q, strap_d;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= SETTLE;
            cnt_q   <= '0;
            strap_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            strap_q <= strap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        strap_d = strap_q;
        unique case (state_q)
            SETTLE: begin
                if (cnt_q == LastCnt) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            LATCH: begin
                // Straps and the RUN state land on the same edge, so valid and
                // value are never seen out of step.
                strap_d = strap_sync_q[SYNC_STAGES-1];
                state_d = RUN;
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = SETTLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic run;
    assign run = (state_q == RUN);

    assign bus.strap_o       = strap_q;
    assign bus.strap_valid_o = run;
    assign bus.pad_oe_o      = bus.core_oe_i & {N_IO{run}};
    assign bus.pad_out_o     = bus.core_out_i;
    assign bus.pad_cfg_o     = bus.pad_cfg_i;

endmodule
